// File: rtl/tt_divider_pkg.sv
// Shared types and pin constants for the sequential divider tile.
package tt_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int START_BIT = 0;
    localparam int BUSY_BIT  = 1;
    localparam int DONE_BIT  = 2;
    localparam int DBZ_BIT   = 3;

    localparam logic [7:0] UIO_OE_VALUE = 8'b0000_1110;

    // Quotient reported for a zero divisor; sliced to the operand width by the core.
    localparam logic [31:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/divu_core.sv
// Generic W-bit restoring divider: one quotient bit per clock, start/busy/done handshake.
module divu_core
    import tt_divider_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         dbz,
    output logic [W-1:0] q,
    output logic [W-1:0] r
);

    localparam int CW = $clog2(W + 1);

    state_t         state;
    logic [W-1:0]   divisor;
    logic [W-1:0]   rem;
    logic [W-1:0]   dvd;
    logic [CW-1:0]  count;
    logic [2*W-1:0] nxt;

    // One shift-subtract iteration; returns {next remainder, next dividend/quotient}.
    function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem_in,
                                                 input logic [W-1:0] dvd_in,
                                                 input logic [W-1:0] dsr);
        logic        [W:0] shifted;
        logic signed [W:0] trial;
        shifted = {rem_in, dvd_in[W-1]};
        trial   = $signed(shifted - {1'b0, dsr});
        if (trial[W])
            return {shifted[W-1:0], dvd_in[W-2:0], 1'b0};
        else
            return {trial[W-1:0], dvd_in[W-2:0], 1'b1};
    endfunction

    assign nxt = div_step(rem, dvd, divisor);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            divisor <= '0;
            rem     <= '0;
            dvd     <= '0;
            count   <= '0;
            q       <= '0;
            r       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dbz     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        divisor <= b;
                        dvd     <= a;
                        if (b != '0) begin
                            state <= CALC;
                            rem   <= '0;
                            count <= '0;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            dbz   <= 1'b0;
                        end else begin
                            // Zero divisor resolves at the capture edge without iterating.
                            state <= DONE;
                            q     <= DBZ_QUOTIENT[W-1:0];
                            r     <= a;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            dbz   <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    {rem, dvd} <= nxt;
                    count      <= count + 1'b1;
                    if (count == CW'(W - 1)) begin
                        state <= DONE;
                        q     <= nxt[W-1:0];
                        r     <= nxt[2*W-1:W];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tt_um_divider.sv
// TinyTapeout wrapper: maps dividend/divisor pins onto divu_core and packs the result.
module tt_um_divider
    import tt_divider_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int W = 4;

    logic         busy;
    logic         done;
    logic         dbz;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         unused_inputs;

    divu_core #(.W(W)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (uio_in[START_BIT]),
        .a     (ui_in[7:4]),
        .b     (ui_in[3:0]),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .q     (q),
        .r     (r)
    );

    assign uo_out = {q, r};
    assign uio_oe = UIO_OE_VALUE;

    always_comb begin
        uio_out           = '0;
        uio_out[BUSY_BIT] = busy;
        uio_out[DONE_BIT] = done;
        uio_out[DBZ_BIT]  = dbz;
    end

    assign unused_inputs = &{1'b0, uio_in[7:1], ena};

endmodule

// File: tb/tb_tt_um_divider.sv
// Self-checking bench for tt_um_divider: directed scenarios, exhaustive sweep, randomized traffic.
module tb_tt_um_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic       ena;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int n_tests = 0;
    int n_fail  = 0;

    tt_um_divider dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result from plain integer division.
    function automatic logic [7:0] model(input logic [7:0] ab);
        int a, b;
        a = int'(ab[7:4]);
        b = int'(ab[3:0]);
        if (b == 0) return {4'hF, ab[7:4]};
        return {4'(a / b), 4'(a % b)};
    endfunction

    function automatic logic busy_o(); return uio_out[1]; endfunction
    function automatic logic done_o(); return uio_out[2]; endfunction
    function automatic logic dbz_o();  return uio_out[3]; endfunction

    // Waits (bounded) for done after a capture edge; returns edges elapsed.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done_o() && cyc < 12) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        logic [7:0] v;
        logic [7:0] prev;

        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        ena    = 1'b1;

        // Reset held: outputs stay at reset values whatever the inputs do.
        for (int i = 0; i < 4; i++) begin
            ui_in     = 8'($urandom);
            uio_in[0] = 1'b1;
            tick();
            check("rst_uo", uo_out, 8'h00);
            check("rst_uio", uio_out, 8'h00);
            check("rst_oe", uio_oe, 8'h0E);
        end
        uio_in = 8'h00;
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_uo", uo_out, 8'h00);
        check("idle_uio", uio_out, 8'h00);

        // 13 / 4
        ui_in = 8'hD4; uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
        ui_in = 8'h00;
        check("d13_busy_e0", busy_o(), 1'b1);
        check("d13_done_e0", done_o(), 1'b0);
        check("d13_uo_e0", uo_out, 8'h00);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("d13_busy", busy_o(), 1'b1);
            check("d13_done", done_o(), 1'b0);
        end
        tick();
        check("d13_done_e4", done_o(), 1'b1);
        check("d13_busy_e4", busy_o(), 1'b0);
        check("d13_uo", uo_out, 8'h31);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("d13_hold_uo", uo_out, 8'h31);
            check("d13_hold_done", done_o(), 1'b1);
        end

        // 9 / 0
        ui_in = 8'h90; uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
        check("dbz_done", done_o(), 1'b1);
        check("dbz_flag", dbz_o(), 1'b1);
        check("dbz_uo", uo_out, 8'hF9);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dbz_nobusy", busy_o(), 1'b0);
            check("dbz_hold", uo_out, 8'hF9);
        end

        // 15 / 2 with operand and start perturbation during CALC
        ui_in = 8'hF2; uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
        check("pert_done_drop", done_o(), 1'b0);
        check("pert_dbz_drop", dbz_o(), 1'b0);
        check("pert_uo_old", uo_out, 8'hF9);
        tick();
        ui_in = 8'h11; uio_in[0] = 1'b1;
        tick();
        tick();
        uio_in[0] = 1'b0;
        tick();
        check("pert_done", done_o(), 1'b1);
        check("pert_uo", uo_out, 8'h71);

        // Reset during CALC
        ui_in = 8'hE3; uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_uo", uo_out, 8'h00);
        check("midrst_uio", uio_out, 8'h00);
        tick();
        tick();
        check("midrst_hold", uo_out, 8'h00);
        rst_n = 1'b1;
        ui_in = 8'hE3; uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
        wait_done(cyc);
        check("restart_lat", cyc, 4);
        check("restart_uo", uo_out, 8'h42);

        // Exhaustive sweep, start held high back-to-back
        uio_in[0] = 1'b1;
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            ui_in = v;
            tick();
            if (v[3:0] == 4'h0) begin
                check("ex_dbz_done", done_o(), 1'b1);
                check("ex_dbz_flag", dbz_o(), 1'b1);
                check("ex_dbz_uo", uo_out, model(v));
            end else begin
                check("ex_busy", busy_o(), 1'b1);
                wait_done(cyc);
                check("ex_lat", cyc, 4);
                check("ex_dbz", dbz_o(), 1'b0);
                check("ex_uo", uo_out, model(v));
            end
        end
        uio_in[0] = 1'b0;
        tick();

        // Randomized operations with idle gaps and noise during CALC
        prev = uo_out;
        for (int k = 0; k < 60; k++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                ui_in = 8'($urandom);
                tick();
                check("rnd_idle_hold", uo_out, prev);
            end
            v = 8'($urandom);
            ui_in = v;
            uio_in = 8'($urandom) | 8'h01;
            tick();
            uio_in = 8'h00;
            if (v[3:0] == 4'h0) begin
                check("rnd_dbz_uo", uo_out, model(v));
                check("rnd_dbz_flag", dbz_o(), 1'b1);
            end else begin
                check("rnd_hold_e0", uo_out, prev);
                cyc = 0;
                while (!done_o() && cyc < 12) begin
                    ui_in  = 8'($urandom);
                    uio_in = 8'($urandom);
                    tick();
                    cyc++;
                    if (!done_o()) check("rnd_calc_hold", uo_out, prev);
                end
                uio_in = 8'h00;
                check("rnd_lat", cyc, 4);
                check("rnd_uo", uo_out, model(v));
            end
            prev = model(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
